// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with an iterative multiply/divide sequencer.
//   Multiply is shift-add, divide is restoring, one bit per clock; signed ops run
//   on magnitudes with a sign fix-up in a final cycle before HI/LO are written.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start, op    issue strobe and opcode (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a, b         rs / rt operands
//   use_hilo     decode stage needs HI/LO or the sequencer
//   flush        cancel any in-flight operation (and a same-cycle start)
//   hi_q, lo_q   architectural HI and LO
//   busy, done   sequencer running / one-cycle completion pulse
//   stall        hold decode while the sequencer is busy
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_hilo,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;

  logic               op_mul, op_div, op_signed, issue;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_mul    = (op == 3'b001) || (op == 3'b010);
    op_div    = (op == 3'b011) || (op == 3'b100);
    op_signed = (op == 3'b001) || (op == 3'b011);
    issue     = start && !flush && (state == IDLE) && (op_mul || op_div);
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    busy  = (state != IDLE);
    stall = busy && (use_hilo || start);
  end

  // One iteration of either algorithm; the shared accumulator shifts right for
  // multiply and left for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div)
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign fix-up. A zero divisor leaves the dividend magnitude in the remainder,
  // so re-applying the dividend sign restores the original a; MIN/-1 falls out
  // of the unsigned magnitudes without a special case.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = acc[WIDTH-1:0];
    if (div_zero)
      quo_fix = '1;
    else if (neg_res)
      quo_fix = -acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue) state_nx = RUN;
      RUN: begin
        if (flush)                           state_nx = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))   state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (op)
                3'b101:  hi_q <= a;
                3'b110:  lo_q <= a;
                default: begin
                  if (issue) begin
                    is_div   <= op_div;
                    opnd     <= op_div ? b_mag : a_mag;
                    acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    neg_res  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem  <= op_signed && op_div && a[WIDTH-1];
                    div_zero <= op_div && (b == '0);
                    cnt      <= '0;
                  end
                end
              endcase
            end
          end
          RUN: begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
          end
          FIX: begin
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done <= 1'b1;
            cnt  <= '0;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed bench for hilo_muldiv (WIDTH=32 and WIDTH=8 instances).
module tb_hilo_muldiv;
  localparam logic [2:0] OP_NOP = 3'b000, OP_MULT = 3'b001, OP_MULTU = 3'b010,
                         OP_DIV = 3'b011, OP_DIVU = 3'b100, OP_MTHI = 3'b101,
                         OP_MTLO = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, use_hilo = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] hi_q, lo_q;
  logic        busy, done, stall;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, stall8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .use_hilo(use_hilo), .flush(flush), .hi_q(hi_q), .lo_q(lo_q),
    .busy(busy), .done(done), .stall(stall)
  );

  hilo_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .use_hilo(1'b0), .flush(1'b0), .hi_q(hi8), .lo_q(lo8),
    .busy(busy8), .done(done8), .stall(stall8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one start for a single edge; operands are scrambled afterwards.
  task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
  endtask

  // Returns at the sample point of the done cycle (or after the bound expires).
  task automatic wait_done(output int bc);
    int guard;
    bc = 0;
    guard = 0;
    while (!done && guard < 200) begin
      if (busy) bc++;
      @(posedge clk); #1;
      guard++;
    end
    check("done_seen", {63'b0, done}, 64'd1);
  endtask

  initial begin
    int bc, sc, dc, idx, guard;

    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi_q, 0);
    check("rst_lo", lo_q, 0);
    check("rst_busy", {63'b0, busy}, 0);
    check("rst_done", {63'b0, done}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: signed multiply, latency and single done pulse
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(bc);
    check("mult_busy_cycles", bc, 33);
    check("mult_hi", hi_q, 32'hFFFF_FFFF);
    check("mult_lo", lo_q, 32'hFFFF_FFF1);
    @(posedge clk); #1;
    check("mult_done_once", {63'b0, done}, 0);

    // 2: unsigned multiply, signed divide
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    check("multu_hi", hi_q, 32'hFFFF_FFFE);
    check("multu_lo", lo_q, 32'h0000_0001);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(bc);
    check("div_neg_lo", lo_q, 32'hFFFF_FFFD);
    check("div_neg_hi", hi_q, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done(bc);
    check("div_negdiv_lo", lo_q, 32'hFFFF_FFFD);
    check("div_negdiv_hi", hi_q, 32'h0000_0001);

    // 3: divide by zero, signed overflow
    issue(OP_DIVU, 32'h0000_0064, 32'h0000_0000);
    wait_done(bc);
    check("divz_busy_cycles", bc, 33);
    check("divz_lo", lo_q, 32'hFFFF_FFFF);
    check("divz_hi", hi_q, 32'h0000_0064);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    check("ovf_lo", lo_q, 32'h8000_0000);
    check("ovf_hi", hi_q, 32'h0000_0000);

    // 4: start while busy ignored, stall on every busy cycle, back-to-back issue
    issue(OP_DIVU, 32'd100, 32'd7);
    use_hilo = 1'b1;
    bc = 0; sc = 0; idx = 0; guard = 0;
    while (!done && guard < 200) begin
      if (idx >= 5 && idx < 20) begin
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
      end else begin
        start = 1'b0; op = OP_NOP;
      end
      #1;
      if (busy) bc++;
      if (busy && stall) sc++;
      @(posedge clk); #1;
      idx++;
      guard++;
    end
    check("busy_done_seen", {63'b0, done}, 1);
    check("stall_cycles", sc, bc);
    check("busy_div_cycles", bc, 33);
    check("stall_idle", {63'b0, stall}, 0);
    check("busy_div_lo", lo_q, 32'd14);
    check("busy_div_hi", hi_q, 32'd2);
    use_hilo = 1'b0;
    issue(OP_MULTU, 32'd3, 32'd4);
    check("b2b_busy", {63'b0, busy}, 1);
    wait_done(bc);
    check("b2b_lo", lo_q, 32'd12);
    check("b2b_hi", hi_q, 32'd0);

    // 5: MTHI/MTLO, flush mid-run, flush dropping an MT start
    start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi_busy", {63'b0, busy}, 0);
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    check("mt_hi", hi_q, 32'h1234_5678);
    check("mt_lo", lo_q, 32'h9ABC_DEF0);
    check("mt_busy", {63'b0, busy}, 0);
    check("mt_done", {63'b0, done}, 0);
    issue(OP_MULT, 32'd9, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    check("flush_pre_busy", {63'b0, busy}, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 0);
    dc = 0;
    repeat (40) begin
      if (done) dc++;
      @(posedge clk); #1;
    end
    check("flush_no_done", dc, 0);
    check("flush_hi", hi_q, 32'h1234_5678);
    check("flush_lo", lo_q, 32'h9ABC_DEF0);
    start = 1'b1; op = OP_MTHI; a = 32'h0; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP; flush = 1'b0;
    check("flush_mthi_hi", hi_q, 32'h1234_5678);

    // 6: asynchronous reset mid-run, then recovery
    issue(OP_MULT, 32'd3, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    #3;
    rst = 1'b1;
    #1;
    check("arst_hi", hi_q, 0);
    check("arst_lo", lo_q, 0);
    check("arst_busy", {63'b0, busy}, 0);
    check("arst_done", {63'b0, done}, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(OP_MULT, 32'd7, 32'd6);
    wait_done(bc);
    check("post_rst_lo", lo_q, 32'h0000_002A);
    check("post_rst_hi", hi_q, 32'h0000_0000);

    // WIDTH=8 instance: signed multiply
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'hFD; b8 = 8'h05;
    @(posedge clk); #1;
    start8 = 1'b0; op8 = OP_NOP; a8 = 8'h55; b8 = 8'hAA;
    bc = 0; guard = 0;
    while (!done8 && guard < 50) begin
      if (busy8) bc++;
      @(posedge clk); #1;
      guard++;
    end
    check("w8_done_seen", {63'b0, done8}, 1);
    check("w8_busy_cycles", bc, 9);
    check("w8_hi", {56'b0, hi8}, 64'hFF);
    check("w8_lo", {56'b0, lo8}, 64'hF1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
